// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the FSM state encoding and the counter-width function.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic int cnt_w(input int width);
        if ($clog2(width) < 1)
            return 1;
        else
            return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle.
// The driver side uses master; the subtractor uses slave.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout
    );
endinterface

// File: rtl/serial_subtractor_fs.sv
// Single-bit full subtractor cell: d = a - b - bin.
// Purely combinational.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock.
// A start/done handshake issues one operation at a time.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] w_sr_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_bout;
    logic             w_cell_d;
    logic             w_cell_bout;
    logic             w_last;
    logic             w_busy;
    logic             w_done;
    logic             w_accept;

    full_subtractor u_cell (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .bin  (r_borrow),
        .d    (w_cell_d),
        .bout (w_cell_bout)
    );

    // Result bits enter at the MSB so the LSB lands at bit 0 last.
    if (WIDTH == 1) begin : g_sr1
        assign w_sr_nxt = w_cell_d;
    end else begin : g_srn
        assign w_sr_nxt = {w_cell_d, r_sr[WIDTH-1:1]};
    end

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last)
                    w_state_nxt = DONE;
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_sr     <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_d      <= '0;
            r_bout   <= 1'b0;
        end else if (w_accept) begin
            r_sa     <= bus.a;
            r_sb     <= bus.b;
            r_sr     <= '0;
            r_cnt    <= '0;
            r_borrow <= bus.bin;
        end else if (w_busy) begin
            r_sa     <= r_sa >> 1;
            r_sb     <= r_sb >> 1;
            r_sr     <= w_sr_nxt;
            r_cnt    <= r_cnt + 1'b1;
            r_borrow <= w_cell_bout;
            // Publish only a complete result; d stays stable during RUN.
            if (w_last) begin
                r_d    <= w_sr_nxt;
                r_bout <= w_cell_bout;
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.d    = r_d;
    assign bus.bout = r_bout;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed plus randomized checks of serial_subtractor (WIDTH 8 and 1)
// and of the full_subtractor cell against an arithmetic model.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] m_d8 = '0;
    logic       m_bout8 = 1'b0;
    logic       m_d1 = 1'b0;
    logic       m_bout1 = 1'b0;

    logic fa, fb, fbin, fd, fbout;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(1)) if1 ();

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    full_subtractor u_fs (
        .a    (fa),
        .b    (fb),
        .bin  (fbin),
        .d    (fd),
        .bout (fbout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; borrow means a < b + bin.
    function automatic logic [8:0] ref8(input logic [7:0] xa, xb,
                                        input logic xbi);
        int diff;
        logic [7:0] dd;
        diff = int'(xa) - int'(xb) - int'(xbi);
        dd = diff[7:0];
        return {(diff < 0), dd};
    endfunction

    function automatic logic [1:0] ref1(input logic xa, xb, xbi);
        int diff;
        diff = int'(xa) - int'(xb) - int'(xbi);
        return {(diff < 0), diff[0]};
    endfunction

    task automatic op8(input logic [7:0] xa, xb, input logic xbi);
        logic [8:0] r;
        @(negedge clk);
        check("idle8", if8.busy, 0);
        if8.start = 1'b1;
        if8.a = xa;
        if8.b = xb;
        if8.bin = xbi;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if8.start = 1'b0;
            if8.a = 8'($urandom);
            if8.b = 8'($urandom);
            if8.bin = 1'($urandom);
            check("busy8", if8.busy, 1);
            check("nodone8", if8.done, 0);
            check("hold_d8", if8.d, m_d8);
        end
        @(negedge clk);
        r = ref8(xa, xb, xbi);
        m_d8 = r[7:0];
        m_bout8 = r[8];
        check("done8", if8.done, 1);
        check("busyoff8", if8.busy, 0);
        check("d8", if8.d, m_d8);
        check("bout8", if8.bout, m_bout8);
    endtask

    task automatic op1(input logic xa, xb, xbi);
        logic [1:0] r;
        @(negedge clk);
        check("idle1", if1.busy, 0);
        if1.start = 1'b1;
        if1.a = xa;
        if1.b = xb;
        if1.bin = xbi;
        @(negedge clk);
        if1.start = 1'b0;
        if1.a = ~xa;
        if1.b = ~xb;
        check("busy1", if1.busy, 1);
        check("nodone1", if1.done, 0);
        check("hold_d1", if1.d, m_d1);
        @(negedge clk);
        r = ref1(xa, xb, xbi);
        m_d1 = r[0];
        m_bout1 = r[1];
        check("done1", if1.done, 1);
        check("busyoff1", if1.busy, 0);
        check("d1", if1.d, m_d1);
        check("bout1", if1.bout, m_bout1);
    endtask

    initial begin
        logic [7:0] ba [3];
        logic [7:0] bb [3];
        logic       bbi [3];
        logic [8:0] r;
        logic [1:0] r1;
        int         k;

        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.bin = 1'b0;
        fa = 1'b0; fb = 1'b0; fbin = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy8", if8.busy, 0);
        check("rst_done8", if8.done, 0);
        check("rst_d8", if8.d, 0);
        check("rst_bout8", if8.bout, 0);
        check("rst_busy1", if1.busy, 0);
        check("rst_d1", if1.d, 0);
        rst_n = 1'b1;

        // Directed operands
        op8(8'd100, 8'd37, 1'b0);
        op8(8'd5, 8'd9, 1'b0);
        op8(8'h00, 8'h00, 1'b1);
        op8(8'hFF, 8'hFF, 1'b0);
        op8(8'h00, 8'hFF, 1'b1);
        op8(8'hFF, 8'h00, 1'b1);

        // Randomized operands
        for (int i = 0; i < 20; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom));

        // start during RUN is ignored, operands stay captured
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'd100; if8.b = 8'd37; if8.bin = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if8.start = (c == 3);
            if8.a = (c == 3) ? 8'd0 : 8'($urandom);
            if8.b = (c == 3) ? 8'd1 : 8'($urandom);
            check("ign_busy", if8.busy, 1);
        end
        @(negedge clk);
        if8.start = 1'b0;
        m_d8 = 8'd63; m_bout8 = 1'b0;
        check("ign_done", if8.done, 1);
        check("ign_d", if8.d, 63);
        check("ign_bout", if8.bout, 0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("ign_nodone", if8.done, 0);
            check("ign_idle", if8.busy, 0);
        end

        // Reset in the middle of an operation
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'd200; if8.b = 8'd50; if8.bin = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if8.start = 1'b0;
            if (c == 4) rst_n = 1'b0;
        end
        @(negedge clk);
        check("mrst_busy", if8.busy, 0);
        check("mrst_done", if8.done, 0);
        check("mrst_d", if8.d, 0);
        check("mrst_bout", if8.bout, 0);
        rst_n = 1'b1;
        m_d8 = '0; m_bout8 = 1'b0;
        m_d1 = 1'b0; m_bout1 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("mrst_nodone", if8.done, 0);
        end
        op8(8'd7, 8'd3, 1'b0);
        check("mrst_d_after", if8.d, 4);

        // start held high: three back-to-back operations
        for (int i = 0; i < 3; i++) begin
            ba[i] = 8'($urandom);
            bb[i] = 8'($urandom);
            bbi[i] = 1'($urandom);
        end
        @(negedge clk);
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            if (c % 10 == 9) begin
                k = c / 10;
                r = ref8(ba[k], bb[k], bbi[k]);
                m_d8 = r[7:0];
                m_bout8 = r[8];
            end
            check("b2b_done", if8.done, (c % 10 == 9));
            check("b2b_busy", if8.busy,
                  (c % 10 >= 1) && (c % 10 <= 8));
            check("b2b_d", if8.d, m_d8);
            check("b2b_bout", if8.bout, m_bout8);
            if (c % 10 == 0 && c / 10 < 3) begin
                k = c / 10;
                if8.start = 1'b1;
                if8.a = ba[k]; if8.b = bb[k]; if8.bin = bbi[k];
            end else if (c % 10 == 1 && c / 10 + 1 < 3) begin
                k = c / 10 + 1;
                if8.a = ba[k]; if8.b = bb[k]; if8.bin = bbi[k];
            end
        end
        if8.start = 1'b0;
        @(negedge clk);
        check("b2b_idle", if8.busy, 0);

        // WIDTH=1 instance
        op1(1'b0, 1'b1, 1'b0);
        check("w1_d", if1.d, 1);
        check("w1_bout", if1.bout, 1);
        for (int i = 0; i < 8; i++)
            op1(i[2], i[1], i[0]);

        // Cell truth table
        for (int i = 0; i < 8; i++) begin
            fa = i[2]; fb = i[1]; fbin = i[0];
            #1;
            r1 = ref1(fa, fb, fbin);
            check("fs_d", fd, r1[0]);
            check("fs_bout", fbout, r1[1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
